// File: rtl/phase_sequencer.sv
// Multi-cycle control sequencer: one-hot fetch/read/execute/memory/writeback phases,
// memory request/acknowledge stalls, sticky halt request and memory-timeout bus error.
module phase_sequencer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             mem_access,
    input  logic             mem_ack,
    input  logic             halt_req,
    input  logic             run,
    output logic [4:0]       phase,
    output logic             mem_req,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [2:0] S_BOOT = 3'd0;
    localparam logic [2:0] S_F    = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_X    = 3'd3;
    localparam logic [2:0] S_M    = 3'd4;
    localparam logic [2:0] S_W    = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;

    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              halt_pend;
    logic              waiting;
    logic              timeout_hit;
    logic              retire;

    always_comb begin
        phase = 5'b00000;
        case (state)
            S_F:     phase = 5'b00001;
            S_R:     phase = 5'b00010;
            S_X:     phase = 5'b00100;
            S_M:     phase = 5'b01000;
            S_W:     phase = 5'b10000;
            default: phase = 5'b00000;
        endcase
    end

    // Handshake: a transfer completes on a rising edge where mem_req and mem_ack are
    // both high; mem_ack is ignored while mem_req is low and need not be held afterwards.
    assign mem_req = phase[0] | (phase[3] & mem_access);

    assign waiting     = mem_req & ~mem_ack;
    assign timeout_hit = (TIMEOUT != 0) && waiting && (wait_cnt == WAIT_LAST);
    assign retire      = (state == S_W);

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT: state_nxt = S_F;
            S_F: begin
                if (mem_ack)
                    state_nxt = S_R;
                else if (timeout_hit)
                    state_nxt = S_HALT;
            end
            S_R: state_nxt = S_X;
            S_X: state_nxt = S_M;
            S_M: begin
                if (!mem_access || mem_ack)
                    state_nxt = S_W;
                else if (timeout_hit)
                    state_nxt = S_HALT;
            end
            // A halt request arriving on the writeback edge itself still takes effect.
            S_W: state_nxt = (halt_pend || halt_req) ? S_HALT : S_F;
            S_HALT: begin
                if (run)
                    state_nxt = S_F;
            end
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= S_BOOT;
            wait_cnt    <= '0;
            halt_pend   <= 1'b0;
            halted      <= 1'b0;
            bus_error   <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nxt;

            // Any state change restarts the wait count, which covers entry to F and M.
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 1'b1;

            if (state_nxt == S_HALT)
                halt_pend <= 1'b0;
            else if (halt_req && state != S_HALT)
                halt_pend <= 1'b1;

            halted <= (state_nxt == S_HALT);

            if (timeout_hit)
                bus_error <= 1'b1;
            else if (state == S_HALT && run)
                bus_error <= 1'b0;

            if (retire)
                instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: scripted cycle-by-cycle stimulus with the expected
// output vector queued per cycle and compared after the clock edge.
module tb_phase_sequencer;

    localparam int CNT_W = 32;
    localparam int W     = 5 + 3 + CNT_W;

    localparam logic [4:0] P_0 = 5'b00000;
    localparam logic [4:0] P_F = 5'b00001;
    localparam logic [4:0] P_R = 5'b00010;
    localparam logic [4:0] P_X = 5'b00100;
    localparam logic [4:0] P_M = 5'b01000;
    localparam logic [4:0] P_W = 5'b10000;

    logic             clk;
    logic             n_rst;
    logic             mem_access;
    logic             mem_ack;
    logic             halt_req;
    logic             run;
    logic [4:0]       phase;
    logic             mem_req;
    logic             halted;
    logic             bus_error;
    logic [CNT_W-1:0] instr_count;

    logic [W-1:0] exp_q[$];
    int n_cmp;
    int n_bad;

    phase_sequencer #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .mem_access  (mem_access),
        .mem_ack     (mem_ack),
        .halt_req    (halt_req),
        .run         (run),
        .phase       (phase),
        .mem_req     (mem_req),
        .halted      (halted),
        .bus_error   (bus_error),
        .instr_count (instr_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, got=%0d compares required=finish", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] outs();
        return {phase, mem_req, halted, bus_error, instr_count};
    endfunction

    function automatic logic [W-1:0] pack(input logic [4:0] ph, input logic rq, input logic hl,
                                           input logic be, input logic [CNT_W-1:0] cn);
        return {ph, rq, hl, be, cn};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got phase=%b req=%b halted=%b berr=%b cnt=%0d, expected phase=%b req=%b halted=%b berr=%b cnt=%0d",
                     tag, got[W-1 -: 5], got[CNT_W+2], got[CNT_W+1], got[CNT_W], got[CNT_W-1:0],
                     exp[W-1 -: 5], exp[CNT_W+2], exp[CNT_W+1], exp[CNT_W], exp[CNT_W-1:0]);
        end
    endtask

    // driver: apply inputs for one edge, queue the outputs expected after it, then compare
    task automatic cyc(input string tag, input logic ack, input logic acc, input logic hq,
                       input logic rn, input logic [4:0] ph, input logic rq, input logic hl,
                       input logic be, input logic [CNT_W-1:0] cn);
        mem_ack    = ack;
        mem_access = acc;
        halt_req   = hq;
        run        = rn;
        exp_q.push_back(pack(ph, rq, hl, be, cn));
        @(posedge clk);
        #1;
        check(tag, outs(), exp_q.pop_front());
    endtask

    initial begin
        logic [4:0] ph;
        n_cmp      = 0;
        n_bad      = 0;
        n_rst      = 1'b0;
        mem_ack    = 1'b0;
        mem_access = 1'b0;
        halt_req   = 1'b0;
        run        = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", outs(), pack(P_0, 0, 0, 0, 0));
        n_rst = 1'b1;
        #1;
        check("boot", outs(), pack(P_0, 0, 0, 0, 0));

        // zero-wait memory, no data access: five-cycle instructions
        for (int k = 1; k <= 16; k++) begin
            ph = P_F << ((k - 1) % 5);
            cyc("zero_wait_seq", 1, 0, 0, 0, ph, ((k - 1) % 5) == 0, 0, 0, CNT_W'((k - 1) / 5));
        end

        // fetch held for three wait cycles; ack arrives on the last allowed edge
        for (int k = 0; k < 3; k++)
            cyc("f_wait", 0, 0, 0, 0, P_F, 1, 0, 0, 3);
        cyc("f_ack", 1, 0, 0, 0, P_R, 0, 0, 0, 3);
        cyc("x_after_fwait", 1, 0, 0, 0, P_X, 0, 0, 0, 3);

        // data access in M with two wait cycles
        cyc("m_enter", 0, 1, 0, 0, P_M, 1, 0, 0, 3);
        cyc("m_wait1", 0, 1, 0, 0, P_M, 1, 0, 0, 3);
        cyc("m_wait2", 0, 1, 0, 0, P_M, 1, 0, 0, 3);
        cyc("m_ack", 1, 1, 0, 0, P_W, 0, 0, 0, 3);
        cyc("retire4", 1, 0, 0, 0, P_F, 1, 0, 0, 4);

        // halt request during X: instruction completes, then HALT
        cyc("r5", 1, 0, 0, 0, P_R, 0, 0, 0, 4);
        cyc("x5", 1, 0, 0, 0, P_X, 0, 0, 0, 4);
        cyc("halt_in_x", 1, 0, 1, 0, P_M, 0, 0, 0, 4);
        cyc("w_after_halt", 1, 0, 0, 0, P_W, 0, 0, 0, 4);
        cyc("halt_entered", 1, 0, 0, 0, P_0, 0, 1, 0, 5);
        cyc("halt_req_ignored", 1, 0, 1, 0, P_0, 0, 1, 0, 5);
        cyc("run_to_f", 1, 0, 0, 1, P_F, 1, 0, 0, 5);

        // latch was cleared: next instruction runs; halt on the W edge itself
        cyc("r6", 1, 0, 0, 0, P_R, 0, 0, 0, 5);
        cyc("x6", 1, 0, 0, 0, P_X, 0, 0, 0, 5);
        cyc("m6_no_access", 1, 0, 0, 0, P_M, 0, 0, 0, 5);
        cyc("w6", 1, 0, 0, 0, P_W, 0, 0, 0, 5);
        cyc("halt_on_w_edge", 1, 0, 1, 0, P_0, 0, 1, 0, 6);
        cyc("run_again", 1, 0, 0, 1, P_F, 1, 0, 0, 6);

        // fetch timeout after four wait cycles; run outside HALT is ignored
        cyc("to_wait1_run_ignored", 0, 0, 0, 1, P_F, 1, 0, 0, 6);
        cyc("to_wait2", 0, 0, 0, 0, P_F, 1, 0, 0, 6);
        cyc("to_wait3", 0, 0, 0, 0, P_F, 1, 0, 0, 6);
        cyc("timeout", 0, 0, 0, 0, P_0, 0, 1, 1, 6);
        cyc("timeout_sticky", 0, 0, 0, 0, P_0, 0, 1, 1, 6);
        cyc("run_clears_berr", 1, 0, 0, 1, P_F, 1, 0, 0, 6);

        // reset asserted during an M wait
        cyc("r7", 1, 0, 0, 0, P_R, 0, 0, 0, 6);
        cyc("x7", 1, 0, 0, 0, P_X, 0, 0, 0, 6);
        cyc("m7_enter", 0, 1, 0, 0, P_M, 1, 0, 0, 6);
        cyc("m7_wait", 0, 1, 0, 0, P_M, 1, 0, 0, 6);
        n_rst = 1'b0;
        #1;
        check("async_reset", outs(), pack(P_0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("reset_held", outs(), pack(P_0, 0, 0, 0, 0));
        n_rst = 1'b1;
        #1;
        check("boot_again", outs(), pack(P_0, 0, 0, 0, 0));
        cyc("f_after_reset", 1, 0, 0, 0, P_F, 1, 0, 0, 0);
        cyc("r_after_reset", 1, 0, 0, 0, P_R, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
